pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
- Parametrised hazard-detection and forwarding-control block for the in-order pipelined CPU.
- Replaces the single-expression stall equation that sits inside the datapath.
- Tracks destination-register tags for every stage after DR in a tag shift pipeline.
- Each cycle it decides, per DR source operand, whether to forward (and from which stage) or stall. Also counts stall cycles for performance monitoring.

Parameters:
- RA_W, 4, register-address width; register 0 is hardwired zero.
- DEPTH, 3, number of tracked stages after DR (0 = EX, 1 = MEM, ..., DEPTH-1 = WB); minimum 2.
- FWD_EN, 1, 1 = forwarding mode; 0 = stall-only mode (legacy behaviour).
- SEL_W, 2, forward-select width; must satisfy 2^SEL_W >= DEPTH+1.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  pipeline advance; 0 freezes all tags and the counter.
- flush  in  1  DR instruction is squashed; a bubble enters EX.
- dr_ra1  in  RA_W  source register 1 of the instruction in DR.
- dr_ra2  in  RA_W  source register 2 of the instruction in DR.
- dr_use1  in  1  dr_ra1 is actually read.
- dr_use2  in  1  dr_ra2 is actually read.
- dr_wa3  in  RA_W  destination register of the DR instruction.
- dr_we3  in  1  the DR instruction writes the register file.
- dr_load  in  1  the result is available only at the end of the MEM stage (LW).
- stall  out  1  hold PC and IF/DR; insert a bubble into EX.
- fwd_sel1  out  SEL_W  forward source for operand 1: 0 = regfile, k+1 = stage k result.
- fwd_sel2  out  SEL_W  forward source for operand 2; same encoding as fwd_sel1.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- State:
  - tag[0..DEPTH-1], each entry {valid, wa, load}.
  - stall_cnt register.
- Reset (reset=0, asynchronous):
  - All tag.valid=0 and stall_cnt=0.
  - Consequently stall=0, fwd_sel1=0, fwd_sel2=0 while reset is held and on the first cycle after release.
- Match rule, per operand n and stage k:
  - match[n][k] = use_n & tag[k].valid & (tag[k].wa == dr_ran) & (dr_ran != 0).
  - Register 0 never matches.
- FWD_EN=0:
  - stall = OR of all match bits (any stage, including WB).
  - fwd_sel1 = fwd_sel2 = 0 at all times.
- FWD_EN=1:
  - For each operand, the youngest matching stage k (lowest index) wins.
  - fwd_seln = k+1, or 0 if there is no match.
  - Load-use hazard: if the winning k=0 and tag[0].load=1, stall=1 and that operand's fwd_seln=0.
  - A load at k>=1 forwards normally.
  - stall is the OR of the load-use conditions of both operands.
- Timing: stall and fwd_sel are combinational from the current tags and the DR inputs, with zero latency.
- Tag shift, on a rising edge with enable=1:
  - tag[k] <= tag[k-1] for k>=1; the WB tag is discarded.
  - tag[0] <= bubble (valid=0) if stall | flush | ~dr_we3.
  - Otherwise tag[0] <= {1, dr_wa3, dr_load}.
  - A write to register 0 enters as valid but never matches.
- enable=0: tags and stall_cnt hold; outputs keep reflecting the current inputs.
- stall_cnt increments by 1 on each edge where enable=1 and stall=1. It saturates at all-ones and never wraps.
- Simultaneous stall and flush: a bubble is inserted. The flush takes priority for the external IF/DR control, which is outside this block.
- Both operands hazarding on different stages: the select for each operand is resolved independently.
- Reset asserted mid-stall: stall drops immediately (asynchronously) and the counter clears.

Test Plan:
- Reset, then `ADD r3` followed by `ADD r4=r3+r5` (FWD_EN=1) -> the cycle after issue has fwd_sel1=1, stall=0, and stall_cnt stays 0.
- `LW r2` followed by `SUB r6=r2-r1` (FWD_EN=1) -> exactly 1 stall cycle with fwd_sel1=0. The next cycle has fwd_sel1=2 (MEM) and stall=0; stall_cnt=1.
- The same ADD pair with FWD_EN=0, DEPTH=3 -> stall=1 for 3 consecutive cycles, then stall=0; stall_cnt=3.
- A writer to r0 followed by a reader of r0, plus a reader of r7 with dr_use2=0 while r7 is pending -> stall=0 and both fwd_sel=0.
- `ADD r5` in MEM, `ADD r5` in EX, reader of r5 -> fwd_sel=1 (youngest wins); then flush the DR writer -> tag[0] is a bubble.
- Force a continuous load-use hazard for 2^CNT_W+5 cycles with CNT_W=4 -> stall_cnt holds at 15. Then assert reset low mid-stall -> stall=0 and stall_cnt=0 immediately; enable=0 freezes the tags.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// DR-stage operand/destination info in, hazard decisions and stall count out.
interface pipe_hazard_if #(
  parameter int unsigned RA_W  = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned CNT_W = 16
);
  logic             enable;
  logic             flush;
  logic [RA_W-1:0]  dr_ra1;
  logic [RA_W-1:0]  dr_ra2;
  logic             dr_use1;
  logic             dr_use2;
  logic [RA_W-1:0]  dr_wa3;
  logic             dr_we3;
  logic             dr_load;
  logic             stall;
  logic [SEL_W-1:0] fwd_sel1;
  logic [SEL_W-1:0] fwd_sel2;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output enable, flush, dr_ra1, dr_ra2, dr_use1, dr_use2, dr_wa3, dr_we3, dr_load,
    input  stall, fwd_sel1, fwd_sel2, stall_cnt
  );

  modport slave (
    input  enable, flush, dr_ra1, dr_ra2, dr_use1, dr_use2, dr_wa3, dr_we3, dr_load,
    output stall, fwd_sel1, fwd_sel2, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and forwarding control: tracks destination tags of the
// stages after DR and decides, per DR source operand, forward or stall.
module pipe_hazard_unit #(
  parameter int unsigned RA_W   = 4,
  parameter int unsigned DEPTH  = 3,
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input logic         clk,
  input logic         reset,
  pipe_hazard_if.slave hz
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] wa;
    logic            load;
  } tag_t;

  tag_t             tags [DEPTH];
  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;
  logic [SEL_W-1:0] sel1;
  logic [SEL_W-1:0] sel2;
  logic             lu1;
  logic             lu2;
  logic             stall_c;
  logic [CNT_W-1:0] cnt;

  // Per-stage operand match; register 0 never matches.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      match1[k] = hz.dr_use1 & tags[k].valid & (tags[k].wa == hz.dr_ra1) & (hz.dr_ra1 != '0);
      match2[k] = hz.dr_use2 & tags[k].valid & (tags[k].wa == hz.dr_ra2) & (hz.dr_ra2 != '0);
    end
  end

  // Youngest match wins; a load still in EX cannot be forwarded and stalls.
  always_comb begin
    sel1    = '0;
    sel2    = '0;
    lu1     = 1'b0;
    lu2     = 1'b0;
    stall_c = 1'b0;
    if (FWD_EN) begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (match1[k]) sel1 = SEL_W'(k + 1);
        if (match2[k]) sel2 = SEL_W'(k + 1);
      end
      lu1 = match1[0] & tags[0].load;
      lu2 = match2[0] & tags[0].load;
      if (lu1) sel1 = '0;
      if (lu2) sel2 = '0;
      stall_c = lu1 | lu2;
    end else begin
      stall_c = (|match1) | (|match2);
    end
  end

  assign hz.stall     = stall_c;
  assign hz.fwd_sel1  = sel1;
  assign hz.fwd_sel2  = sel2;
  assign hz.stall_cnt = cnt;

  // Tag shift pipeline; stalled, flushed or non-writing DR enters as a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < int'(DEPTH); k++) tags[k] <= '0;
    end else if (hz.enable) begin
      for (int k = 1; k < int'(DEPTH); k++) tags[k] <= tags[k-1];
      if (stall_c | hz.flush | ~hz.dr_we3) tags[0] <= '0;
      else                                 tags[0] <= {1'b1, hz.dr_wa3, hz.dr_load};
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (hz.enable && stall_c && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench: forwarding instance, stall-only instance and a narrow-counter
// instance all driven by the same DR stimulus.
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       flush;
  logic [3:0] ra1, ra2, wa3;
  logic       use1, use2, we3, ld;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_if #(.RA_W(4), .SEL_W(2), .CNT_W(16)) if_f ();
  pipe_hazard_if #(.RA_W(4), .SEL_W(2), .CNT_W(16)) if_s ();
  pipe_hazard_if #(.RA_W(4), .SEL_W(2), .CNT_W(4))  if_c ();

  assign if_f.enable = enable;  assign if_s.enable = enable;  assign if_c.enable = enable;
  assign if_f.flush  = flush;   assign if_s.flush  = flush;   assign if_c.flush  = flush;
  assign if_f.dr_ra1 = ra1;     assign if_s.dr_ra1 = ra1;     assign if_c.dr_ra1 = ra1;
  assign if_f.dr_ra2 = ra2;     assign if_s.dr_ra2 = ra2;     assign if_c.dr_ra2 = ra2;
  assign if_f.dr_use1 = use1;   assign if_s.dr_use1 = use1;   assign if_c.dr_use1 = use1;
  assign if_f.dr_use2 = use2;   assign if_s.dr_use2 = use2;   assign if_c.dr_use2 = use2;
  assign if_f.dr_wa3 = wa3;     assign if_s.dr_wa3 = wa3;     assign if_c.dr_wa3 = wa3;
  assign if_f.dr_we3 = we3;     assign if_s.dr_we3 = we3;     assign if_c.dr_we3 = we3;
  assign if_f.dr_load = ld;     assign if_s.dr_load = ld;     assign if_c.dr_load = ld;

  pipe_hazard_unit #(.RA_W(4), .DEPTH(3), .FWD_EN(1'b1), .SEL_W(2), .CNT_W(16)) u_fwd (
    .clk(clk), .reset(reset), .hz(if_f.slave));
  pipe_hazard_unit #(.RA_W(4), .DEPTH(3), .FWD_EN(1'b0), .SEL_W(2), .CNT_W(16)) u_stl (
    .clk(clk), .reset(reset), .hz(if_s.slave));
  pipe_hazard_unit #(.RA_W(4), .DEPTH(3), .FWD_EN(1'b1), .SEL_W(2), .CNT_W(4)) u_cnt (
    .clk(clk), .reset(reset), .hz(if_c.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic dr(input logic [3:0] a1, input logic u1, input logic [3:0] a2,
                    input logic u2, input logic [3:0] wa, input logic we, input logic l);
    ra1 = a1; use1 = u1; ra2 = a2; use2 = u2; wa3 = wa; we3 = we; ld = l;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    dr(0, 0, 0, 0, 0, 0, 0);
    flush = 1'b0;
    enable = 1'b1;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; flush = 1'b0;
    dr(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_stall",    32'(if_f.stall), 32'd0);
    chk("rst_sel1",     32'(if_f.fwd_sel1), 32'd0);
    chk("rst_sel2",     32'(if_f.fwd_sel2), 32'd0);
    chk("rst_cnt",      32'(if_f.stall_cnt), 32'd0);
    step();
    reset = 1'b1;
    dr(3, 1, 5, 1, 4, 1, 0);
    #1;
    chk("post_rst_stall", 32'(if_f.stall), 32'd0);
    chk("post_rst_sel1",  32'(if_f.fwd_sel1), 32'd0);
    chk("post_rst_stl",   32'(if_s.stall), 32'd0);

    // ADD r3 ; ADD r4 = r3 + r5
    do_reset();
    dr(1, 1, 2, 1, 3, 1, 0);
    #1;
    chk("add_issue_stall", 32'(if_f.stall), 32'd0);
    step();
    dr(3, 1, 5, 1, 4, 1, 0);
    #1;
    chk("add_fwd_sel1",  32'(if_f.fwd_sel1), 32'd1);
    chk("add_fwd_sel2",  32'(if_f.fwd_sel2), 32'd0);
    chk("add_fwd_stall", 32'(if_f.stall), 32'd0);
    chk("stl_c1_stall",  32'(if_s.stall), 32'd1);
    chk("stl_sel1",      32'(if_s.fwd_sel1), 32'd0);
    step();
    chk("add_fwd_cnt",   32'(if_f.stall_cnt), 32'd0);
    chk("stl_c2_stall",  32'(if_s.stall), 32'd1);
    step();
    chk("stl_c3_stall",  32'(if_s.stall), 32'd1);
    step();
    chk("stl_c4_stall",  32'(if_s.stall), 32'd0);
    chk("stl_cnt",       32'(if_s.stall_cnt), 32'd3);

    // LW r2 ; SUB r6 = r2 - r1
    do_reset();
    dr(0, 0, 0, 0, 2, 1, 1);
    step();
    dr(2, 1, 1, 1, 6, 1, 0);
    #1;
    chk("lu_stall",  32'(if_f.stall), 32'd1);
    chk("lu_sel1",   32'(if_f.fwd_sel1), 32'd0);
    chk("lu_sel2",   32'(if_f.fwd_sel2), 32'd0);
    step();
    chk("lu_after_stall", 32'(if_f.stall), 32'd0);
    chk("lu_after_sel1",  32'(if_f.fwd_sel1), 32'd2);
    chk("lu_cnt",         32'(if_f.stall_cnt), 32'd1);
    chk("lu_cnt_narrow",  32'(if_c.stall_cnt), 32'd1);

    // r0 writer, r7 writer, reader of r0 and (unused) r7
    do_reset();
    dr(0, 0, 0, 0, 0, 1, 0);
    step();
    dr(0, 0, 0, 0, 7, 1, 0);
    step();
    dr(0, 1, 7, 0, 8, 1, 0);
    #1;
    chk("r0_stall",     32'(if_f.stall), 32'd0);
    chk("r0_sel1",      32'(if_f.fwd_sel1), 32'd0);
    chk("r0_sel2",      32'(if_f.fwd_sel2), 32'd0);
    chk("r0_stl_stall", 32'(if_s.stall), 32'd0);
    use2 = 1'b1;
    #1;
    chk("r7_used_sel2", 32'(if_f.fwd_sel2), 32'd1);
    chk("r7_used_stl",  32'(if_s.stall), 32'd1);

    // Youngest of two r5 writers wins; flushed DR writer leaves a bubble
    do_reset();
    dr(0, 0, 0, 0, 5, 1, 0);
    step();
    step();
    dr(5, 1, 5, 1, 9, 1, 0);
    flush = 1'b1;
    #1;
    chk("young_sel1", 32'(if_f.fwd_sel1), 32'd1);
    chk("young_sel2", 32'(if_f.fwd_sel2), 32'd1);
    step();
    flush = 1'b0;
    dr(9, 1, 5, 1, 10, 0, 0);
    #1;
    chk("flush_sel1", 32'(if_f.fwd_sel1), 32'd0);
    chk("flush_sel2", 32'(if_f.fwd_sel2), 32'd2);

    // Repeated load-use (stalls on every other cycle) to saturate the 4-bit counter
    do_reset();
    dr(2, 1, 0, 0, 2, 1, 1);
    for (int i = 0; i < 28; i++) step();
    chk("sat_cnt14",      32'(if_c.stall_cnt), 32'd14);
    chk("sat_fwd_cnt14",  32'(if_f.stall_cnt), 32'd14);
    for (int i = 0; i < 14; i++) step();
    chk("sat_cnt15",      32'(if_c.stall_cnt), 32'd15);
    chk("sat_fwd_cnt21",  32'(if_f.stall_cnt), 32'd21);
    step();
    chk("sat_stall_on",   32'(if_c.stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_stall", 32'(if_c.stall), 32'd0);
    chk("async_rst_cnt",   32'(if_c.stall_cnt), 32'd0);
    chk("async_rst_fcnt",  32'(if_f.stall_cnt), 32'd0);
    dr(0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b1;

    // enable=0 freezes tags and counter while outputs track inputs
    dr(0, 0, 0, 0, 3, 1, 1);
    step();
    dr(3, 1, 0, 0, 8, 1, 0);
    enable = 1'b0;
    #1;
    chk("frz_stall0", 32'(if_f.stall), 32'd1);
    step();
    step();
    chk("frz_stall2", 32'(if_f.stall), 32'd1);
    chk("frz_sel1",   32'(if_f.fwd_sel1), 32'd0);
    chk("frz_cnt",    32'(if_f.stall_cnt), 32'd0);
    enable = 1'b1;
    step();
    chk("unfrz_stall", 32'(if_f.stall), 32'd0);
    chk("unfrz_sel1",  32'(if_f.fwd_sel1), 32'd2);
    chk("unfrz_cnt",   32'(if_f.stall_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
